prog_loader: RTL

Boot and program-load sequencer for the one-cycle CPU. It holds the CPU halted and in reset while it receives a program as a byte stream over a valid/ready handshake. It writes each 13-bit instruction into instruction memory, verifies an XOR checksum, then releases the CPU to run. It sits between the external host link and the `cpu_main` instruction memory and clock-enable.

---
 rtl/prog_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot/program-load sequencer: receives a byte stream, writes 13-bit words to
// instruction memory, verifies an XOR checksum, then releases the CPU.
module prog_loader #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  GO,
  input  logic [BYTE_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic [ADDR_WIDTH-1:0] I_MEM_ADDR,
  output logic [WIDTH-1:0]      I_MEM_DATA,
  output logic                  I_MEM_WE,
  output logic                  CPU_EN,
  output logic                  CPU_RST,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LO, S_HI, S_WRITE, S_CSUM, S_RUN, S_ERR
  } state_t;

  // A count byte of zero encodes a full 2^ADDR_WIDTH-word image.
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [BYTE_WIDTH-1:0] lo_q,    lo_d;
  logic [BYTE_WIDTH-1:0] hi_q,    hi_d;
  logic [BYTE_WIDTH-1:0] csum_q,  csum_d;
  logic                  xfer;
  logic                  last_word;

  assign xfer       = RX_VALID && RX_READY;
  assign last_word  = ({1'b0, addr_q} == (count_q - (ADDR_WIDTH+1)'(1)));
  assign I_MEM_ADDR = addr_q;
  assign I_MEM_DATA = {hi_q[WIDTH-BYTE_WIDTH-1:0], lo_q};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    unique case (state_q)
      S_IDLE: begin
        if (START)   state_d = S_LEN;
        else if (GO) state_d = S_RUN;
      end
      S_LEN: if (xfer) begin
        count_d = (RX_DATA == '0) ? FULL_COUNT : {1'b0, ADDR_WIDTH'(RX_DATA)};
        csum_d  = RX_DATA;
        addr_d  = '0;
        state_d = S_LO;
      end
      S_LO: if (xfer) begin
        lo_d    = RX_DATA;
        csum_d  = csum_q ^ RX_DATA;
        state_d = S_HI;
      end
      S_HI: if (xfer) begin
        hi_d    = RX_DATA;
        csum_d  = csum_q ^ RX_DATA;
        state_d = S_WRITE;
      end
      // The address holds on the final word so the counter never wraps.
      S_WRITE: begin
        if (last_word) begin
          state_d = S_CSUM;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_LO;
        end
      end
      S_CSUM: if (xfer) state_d = (RX_DATA == csum_q) ? S_RUN : S_ERR;
      S_RUN:  if (START) state_d = S_LEN;
      S_ERR:  if (START) state_d = S_LEN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    RX_READY = 1'b0;
    I_MEM_WE = 1'b0;
    CPU_EN   = 1'b0;
    CPU_RST  = 1'b1;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    ERR      = 1'b0;
    unique case (state_q)
      S_LEN, S_LO, S_HI, S_CSUM: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
      end
      S_WRITE: begin
        I_MEM_WE = 1'b1;
        BUSY     = 1'b1;
      end
      S_RUN: begin
        CPU_EN  = 1'b1;
        CPU_RST = 1'b0;
        DONE    = 1'b1;
      end
      S_ERR:  ERR = 1'b1;
      default: ;
    endcase
  end

endmodule
